edubos5_lsu: RTL and testbench

EDUBOS5_LSU -- requirements
Module: edubos5_lsu

---
 rtl/edubos5_pkg.sv | 55 +++++
 rtl/edubos5_lsu_align.sv | 56 +++++
 rtl/edubos5_lsu.sv | 155 +++++++++++++++
 tb/tb_edubos5_lsu.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/edubos5_pkg.sv
// rtl/edubos5_pkg.sv - shared types and decode helpers for the edubos5 load/store unit
package edubos5_pkg;

  typedef logic [31:0] cpu_addr_t;

  typedef enum logic [3:0] {
    WE_NONE   = 4'b0000,
    BYTE1     = 4'b0001,
    HALFWORD1 = 4'b0011,
    HALFWORD2 = 4'b1100,
    WORD      = 4'b1111
  } we_bs_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_load_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } funct3_store_t;

  typedef enum logic [1:0] {
    LSU_OK       = 2'b00,
    LSU_MISALIGN = 2'b01,
    LSU_TIMEOUT  = 2'b10,
    LSU_ILLEGAL  = 2'b11
  } lsu_err_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return (f3 > 3'b010);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // funct3[1:0] encodes access size for both loads and stores
  function automatic logic f3_misalign(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edubos5_lsu_align.sv
// rtl/edubos5_lsu_align.sv - store lane steering and load lane select/extension
// Purely combinational; the LSU feeds it request fields or latched fields by state.
module edubos5_lsu_align
  import edubos5_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  we,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    we          = WE_NONE;
    wdata_lanes = wdata;
    case (funct3)
      F3_SB: begin
        we          = 4'(BYTE1) << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      F3_SH: begin
        we          = addr_lo[1] ? HALFWORD2 : HALFWORD1;
        wdata_lanes = {2{wdata[15:0]}};
      end
      F3_SW:   we = WORD;
      default: we = WE_NONE;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_LB:   rdata_ext = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  rdata_ext = {24'h0, byte_lane};
      F3_LH:   rdata_ext = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  rdata_ext = {16'h0, half_lane};
      F3_LW:   rdata_ext = rdata;
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/edubos5_lsu.sv
// rtl/edubos5_lsu.sv - single-outstanding load/store unit with bus wait timeout
// Decode errors respond without touching the bus; bus accesses end on ack or timeout.
module edubos5_lsu
  import edubos5_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] bus_addr,
  output logic        bus_rd,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  lsu_state_t       state_q, state_d;
  cpu_addr_t        bus_addr_q, bus_addr_d;
  logic             bus_rd_q, bus_rd_d;
  logic [3:0]       bus_we_q, bus_we_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  lsu_err_t         rsp_err_q, rsp_err_d;

  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_we;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  // In IDLE the aligner steers the incoming store; in ACCESS it extends the load reply.
  assign al_funct3  = (state_q == ST_IDLE) ? req_funct3    : funct3_q;
  assign al_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

  edubos5_lsu_align u_align (
    .funct3      (al_funct3),
    .addr_lo     (al_addr_lo),
    .wdata       (req_wdata),
    .rdata       (bus_rdata),
    .we          (al_we),
    .wdata_lanes (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    bus_addr_d  = bus_addr_q;
    bus_rd_d    = bus_rd_q;
    bus_we_d    = bus_we_q;
    bus_wdata_d = bus_wdata_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = LSU_OK;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (f3_illegal(req_store, req_funct3)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = LSU_ILLEGAL;
          end else if (f3_misalign(req_funct3, req_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = LSU_MISALIGN;
          end else begin
            state_d     = ST_ACCESS;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_rd_d    = ~req_store;
            bus_we_d    = req_store ? al_we : 4'h0;
            bus_wdata_d = req_store ? al_wdata : 32'h0;
            funct3_d    = req_funct3;
            addr_lo_d   = req_addr[1:0];
            cnt_d       = '0;
          end
        end
      end

      ST_ACCESS: begin
        if (bus_ack || (TIMEOUT_CYC > 0 && cnt_q == CNT_LAST)) begin
          state_d     = ST_RESP;
          bus_addr_d  = 32'h0;
          bus_rd_d    = 1'b0;
          bus_we_d    = 4'h0;
          bus_wdata_d = 32'h0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus_ack ? LSU_OK : LSU_TIMEOUT;
          rsp_rdata_d = (bus_ack && bus_rd_q) ? al_rdata : 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      bus_addr_q  <= 32'h0;
      bus_rd_q    <= 1'b0;
      bus_we_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= LSU_OK;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      bus_rd_q    <= bus_rd_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_rd    = bus_rd_q;
  assign bus_we    = bus_we_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_edubos5_lsu.sv
// tb/tb_edubos5_lsu.sv - directed and random checks of edubos5_lsu against a byte-level model
module tb_edubos5_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        arst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] bus_addr;
  logic        bus_rd;
  logic [3:0]  bus_we;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  edubos5_lsu #(.TIMEOUT_CYC(TO), .CNT_W(3)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory access viewed as nb bytes starting at byte offset addr[1:0].
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic [1:0] err, output logic [3:0] we,
                                output logic [31:0] wdat, output logic [31:0] rdat);
    int nb;
    bit ill, mis;
    logic [31:0] sh, mask, v;
    nb  = 1 << f3[1:0];
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    mis = (a & 32'(nb - 1)) != 0;
    err = ill ? 2'd3 : (mis ? 2'd1 : 2'd0);
    we  = 4'(((1 << nb) - 1) << a[1:0]);
    if (nb == 1)      wdat = (wd & 32'hFF) * 32'h01010101;
    else if (nb == 2) wdat = (wd & 32'hFFFF) * 32'h00010001;
    else              wdat = wd;
    sh   = rd >> (8 * a[1:0]);
    mask = (nb >= 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nb)) - 1);
    v    = sh & mask;
    if (!f3[2] && nb < 4 && sh[8*nb-1]) v = v | ~mask;
    rdat = v;
  endfunction

  // Called at a negedge; returns at a negedge. ack_at: access cycle carrying ack, 0 = never.
  task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    logic [1:0]  e_err;
    logic [3:0]  e_we;
    logic [31:0] e_wd, e_rd;
    int last;
    bit acked;
    model(st, f3, a, wd, rd, e_err, e_we, e_wd, e_rd);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (e_err != 2'd0) begin
      @(negedge clk);
      chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("err_code", 32'(rsp_err), 32'(e_err));
      chk("err_rdata", rsp_rdata, 32'h0);
      chk("err_no_strobe", {27'h0, bus_rd, bus_we}, 32'h0);
      @(negedge clk);
      chk("err_rsp_drop", 32'(rsp_valid), 32'd0);
      return;
    end
    acked = (ack_at > 0 && ack_at <= TO);
    last  = acked ? ack_at : TO;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      chk("acc_rd", 32'(bus_rd), 32'(!st));
      chk("acc_we", 32'(bus_we), st ? 32'(e_we) : 32'h0);
      chk("acc_addr", bus_addr, a & 32'hFFFFFFFC);
      if (st) chk("acc_wdata", bus_wdata, e_wd);
      chk("acc_no_rsp", {30'h0, rsp_valid, req_ready}, 32'h0);
      bus_ack   = (k == ack_at);
      bus_rdata = (k == ack_at) ? rd : $urandom;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), acked ? 32'd0 : 32'd2);
    chk("rsp_rdata", rsp_rdata, (acked && !st) ? e_rd : 32'h0);
    chk("rsp_strobe_drop", {27'h0, bus_rd, bus_we}, 32'h0);
    @(negedge clk);
    chk("rsp_one_cycle", {30'h0, rsp_valid, req_ready}, 32'h1);
    chk("rsp_err_idle", 32'(rsp_err), 32'd0);
  endtask

  initial begin
    arst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp", {rsp_rdata[29:0], rsp_valid, 1'b0} | 32'(rsp_err), 32'h0);
    chk("rst_bus", {27'h0, bus_rd, bus_we} | bus_addr | bus_wdata, 32'h0);
    arst = 1'b0;
    @(negedge clk);

    // Stray ack while idle must not produce a response
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("stray_ack", {30'h0, rsp_valid, req_ready}, 32'h1);
    end
    bus_ack = 1'b0;

    run(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
    run(1'b0, 3'b000, 32'h202, 32'h0, 32'h12F03456, 1);
    run(1'b0, 3'b100, 32'h202, 32'h0, 32'h12F03456, 1);
    run(1'b0, 3'b101, 32'h202, 32'h0, 32'h12F03456, 1);
    run(1'b0, 3'b001, 32'h202, 32'h0, 32'h8001F003, 2);
    run(1'b1, 3'b001, 32'h002, 32'h0000BEEF, 32'h0, 3);
    run(1'b1, 3'b010, 32'h7FFC, 32'hCAFEF00D, 32'h0, 1);
    run(1'b0, 3'b010, 32'h301, 32'h0, 32'h0, 1);
    run(1'b1, 3'b100, 32'h400, 32'h0, 32'h0, 1);
    run(1'b0, 3'b011, 32'h401, 32'h0, 32'h0, 1);
    run(1'b0, 3'b010, 32'h400, 32'h0, 32'h11223344, 0);
    run(1'b0, 3'b010, 32'h400, 32'h0, 32'h55667788, TO);

    // Reset in the middle of an access
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_rd", 32'(bus_rd), 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("arst_rd_drop", 32'(bus_rd), 32'd0);
    chk("arst_idle", {30'h0, rsp_valid, req_ready}, 32'h1);
    chk("arst_addr", bus_addr, 32'h0);
    @(negedge clk);
    chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
    arst = 1'b0;
    run(1'b0, 3'b100, 32'h603, 32'h0, 32'hA1B2C3D4, 1);

    for (int i = 0; i < 40; i++) begin
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
